// File: rtl/udtimer.sv
// udtimer: up/down interval timer on a ripple chain of 1-bit counter cells.
// Ports: sys_clk, reset, wr_preset, preset, start, stop, dir, autoreload,
// tick, prescale -> count, irq, busy. Option macro: UDTIMER_PRESCALE_EN.
module udtimer #(
  parameter int WIDTH = 16
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             wr_preset,
  input  logic [WIDTH-1:0] preset,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             autoreload,
  input  logic             tick,
  input  logic [7:0]       prescale,
  output logic [WIDTH-1:0] count,
  output logic             irq,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             irq_q, irq_d;

  logic             run;
  logic             tick_ok;
  logic             eff_tick;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] chain_nxt;
  logic             terminal;

  assign run = (state_q == RUN);

  // A load in the same cycle swallows the tick entirely.
  assign tick_ok = tick & run & ~wr_preset;

`ifdef UDTIMER_PRESCALE_EN
  logic [7:0] pcnt_q, pcnt_d;

  assign eff_tick = tick_ok & (pcnt_q == prescale);

  always_comb begin
    pcnt_d = pcnt_q;
    if (tick_ok) begin
      pcnt_d = eff_tick ? 8'd0 : pcnt_q + 8'd1;
    end
    if (start | stop | wr_preset | terminal) begin
      pcnt_d = 8'd0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      pcnt_q <= 8'd0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end
`else
  logic unused_prescale;

  assign unused_prescale = ^prescale;
  assign eff_tick        = tick_ok;
`endif

  // Ripple chain: each cell toggles on carry-in and passes the carry
  // while its bit already equals dir (all-ones up, all-zeros down).
  always_comb begin
    carry[0] = eff_tick;
    for (int i = 0; i < WIDTH; i++) begin
      chain_nxt[i] = count_q[i] ^ carry[i];
      carry[i+1]   = carry[i] & (count_q[i] == dir);
    end
  end

  assign terminal = carry[WIDTH];

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    irq_d    = 1'b0;

    if (wr_preset) begin
      count_d  = preset;
      reload_d = preset;
    end else if (terminal) begin
      // One-shot holds the terminal value instead of wrapping.
      irq_d = 1'b1;
      if (autoreload) begin
        count_d = reload_q;
      end
    end else if (eff_tick) begin
      count_d = chain_nxt;
    end

    case (state_q)
      IDLE: begin
        if (start & ~stop) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop | (terminal & ~autoreload)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      irq_q    <= irq_d;
    end
  end

  assign count = count_q;
  assign irq   = irq_q;
  assign busy  = run;

endmodule

// File: tb/tb_udtimer.sv
// tb_udtimer: scoreboard bench for udtimer (WIDTH = 16).
// Expected per-cycle outputs are queued with the stimulus, popped on output.
module tb_udtimer;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] c;
    logic         i;
    logic         b;
    string        n;
  } exp_t;

  logic         sys_clk = 1'b0;
  logic         reset;
  logic         wr_preset;
  logic [W-1:0] preset;
  logic         start;
  logic         stop;
  logic         dir;
  logic         autoreload;
  logic         tick;
  logic [7:0]   prescale;
  logic [W-1:0] count;
  logic         irq;
  logic         busy;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  udtimer #(.WIDTH(W)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .wr_preset  (wr_preset),
    .preset     (preset),
    .start      (start),
    .stop       (stop),
    .dir        (dir),
    .autoreload (autoreload),
    .tick       (tick),
    .prescale   (prescale),
    .count      (count),
    .irq        (irq),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clr();
    reset     = 1'b0;
    wr_preset = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    tick      = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] c, input logic i,
                      input logic b, input string n);
    exp_t e;
    e.c = c;
    e.i = i;
    e.b = b;
    e.n = n;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    for (int k = 0; k < 9; k++) begin
      clr();
      case (k)
        0, 1: begin
          reset = 1'b1;
          push(16'h0000, 1'b0, 1'b0, "rst_init");
        end
        2: begin
          wr_preset = 1'b1;
          preset    = 16'h1235;
          start     = 1'b1;
          dir       = 1'b0;
          push(16'h1235, 1'b0, 1'b1, "rst_load");
        end
        3: begin
          tick = 1'b1;
          push(16'h1234, 1'b0, 1'b1, "rst_run");
        end
        4, 5: begin
          reset = 1'b1;
          tick  = 1'b1;
          start = 1'b1;
          push(16'h0000, 1'b0, 1'b0, "rst_mid");
        end
        default: begin
          tick = 1'b1;
          push(16'h0000, 1'b0, 1'b0, "rst_idle_tick");
        end
      endcase
      step();
      e = sb.pop_front();
      checks++;
      if ({count, irq, busy} !== {e.c, e.i, e.b}) begin
        errors++;
        $display("FAIL %s k=%0d count=%h irq=%b busy=%b want %h %b %b",
                 e.n, k, count, irq, busy, e.c, e.i, e.b);
      end
    end
  endtask

  task automatic test_oneshot_down();
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      clr();
      case (k)
        0: begin
          wr_preset  = 1'b1;
          preset     = 16'd3;
          dir        = 1'b0;
          autoreload = 1'b0;
          start      = 1'b1;
          push(16'd3, 1'b0, 1'b1, "os_load");
        end
        1: begin tick = 1'b1; push(16'd2, 1'b0, 1'b1, "os_2"); end
        2: begin tick = 1'b1; push(16'd1, 1'b0, 1'b1, "os_1"); end
        3: begin tick = 1'b1; push(16'd0, 1'b0, 1'b1, "os_0"); end
        4: begin tick = 1'b1; push(16'd0, 1'b1, 1'b0, "os_term"); end
        default: begin
          tick = 1'b1;
          push(16'd0, 1'b0, 1'b0, "os_after");
        end
      endcase
      step();
      e = sb.pop_front();
      checks++;
      if ({count, irq, busy} !== {e.c, e.i, e.b}) begin
        errors++;
        $display("FAIL %s k=%0d count=%h irq=%b busy=%b want %h %b %b",
                 e.n, k, count, irq, busy, e.c, e.i, e.b);
      end
    end
  endtask

  task automatic test_autoreload_up();
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      clr();
      case (k)
        0: begin
          wr_preset  = 1'b1;
          preset     = 16'hFFFD;
          dir        = 1'b1;
          autoreload = 1'b1;
          start      = 1'b1;
          push(16'hFFFD, 1'b0, 1'b1, "ar_load");
        end
        1: begin tick = 1'b1; push(16'hFFFE, 1'b0, 1'b1, "ar_fffe"); end
        2: begin tick = 1'b1; push(16'hFFFF, 1'b0, 1'b1, "ar_ffff"); end
        3: begin tick = 1'b1; push(16'hFFFD, 1'b1, 1'b1, "ar_term"); end
        4: begin tick = 1'b1; push(16'hFFFE, 1'b0, 1'b1, "ar_again"); end
        default: begin
          stop = 1'b1;
          push(16'hFFFE, 1'b0, 1'b0, "ar_stop");
        end
      endcase
      step();
      e = sb.pop_front();
      checks++;
      if ({count, irq, busy} !== {e.c, e.i, e.b}) begin
        errors++;
        $display("FAIL %s k=%0d count=%h irq=%b busy=%b want %h %b %b",
                 e.n, k, count, irq, busy, e.c, e.i, e.b);
      end
    end
  endtask

  task automatic test_load_priority();
    exp_t e;
    for (int k = 0; k < 5; k++) begin
      clr();
      case (k)
        0: begin
          wr_preset  = 1'b1;
          preset     = 16'd1;
          dir        = 1'b0;
          autoreload = 1'b1;
          start      = 1'b1;
          push(16'd1, 1'b0, 1'b1, "lp_load");
        end
        1: begin tick = 1'b1; push(16'd0, 1'b0, 1'b1, "lp_zero"); end
        2: begin
          wr_preset = 1'b1;
          preset    = 16'h0010;
          tick      = 1'b1;
          push(16'h0010, 1'b0, 1'b1, "lp_prio");
        end
        3: begin tick = 1'b1; push(16'h000F, 1'b0, 1'b1, "lp_next"); end
        default: begin
          stop = 1'b1;
          push(16'h000F, 1'b0, 1'b0, "lp_stop");
        end
      endcase
      step();
      e = sb.pop_front();
      checks++;
      if ({count, irq, busy} !== {e.c, e.i, e.b}) begin
        errors++;
        $display("FAIL %s k=%0d count=%h irq=%b busy=%b want %h %b %b",
                 e.n, k, count, irq, busy, e.c, e.i, e.b);
      end
    end
  endtask

  task automatic test_start_stop();
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      clr();
      case (k)
        0: begin
          wr_preset  = 1'b1;
          preset     = 16'd5;
          dir        = 1'b1;
          autoreload = 1'b1;
          start      = 1'b1;
          push(16'd5, 1'b0, 1'b1, "ss_load");
        end
        1: begin
          start = 1'b1;
          stop  = 1'b1;
          push(16'd5, 1'b0, 1'b0, "ss_collide");
        end
        2, 3: begin
          tick = 1'b1;
          push(16'd5, 1'b0, 1'b0, "ss_idle_tick");
        end
        4: begin start = 1'b1; push(16'd5, 1'b0, 1'b1, "ss_restart"); end
        default: begin
          stop = 1'b1;
          push(16'd5, 1'b0, 1'b0, "ss_stop");
        end
      endcase
      step();
      e = sb.pop_front();
      checks++;
      if ({count, irq, busy} !== {e.c, e.i, e.b}) begin
        errors++;
        $display("FAIL %s k=%0d count=%h irq=%b busy=%b want %h %b %b",
                 e.n, k, count, irq, busy, e.c, e.i, e.b);
      end
    end
  endtask

  task automatic test_dir_change();
    exp_t e;
    for (int k = 0; k < 5; k++) begin
      clr();
      case (k)
        0: begin
          wr_preset  = 1'b1;
          preset     = 16'h00FF;
          dir        = 1'b1;
          autoreload = 1'b0;
          start      = 1'b1;
          push(16'h00FF, 1'b0, 1'b1, "dc_load");
        end
        1: begin tick = 1'b1; push(16'h0100, 1'b0, 1'b1, "dc_up"); end
        2: begin
          dir  = 1'b0;
          tick = 1'b1;
          push(16'h00FF, 1'b0, 1'b1, "dc_down");
        end
        3: begin tick = 1'b1; push(16'h00FE, 1'b0, 1'b1, "dc_down2"); end
        default: begin
          stop = 1'b1;
          push(16'h00FE, 1'b0, 1'b0, "dc_stop");
        end
      endcase
      step();
      e = sb.pop_front();
      checks++;
      if ({count, irq, busy} !== {e.c, e.i, e.b}) begin
        errors++;
        $display("FAIL %s k=%0d count=%h irq=%b busy=%b want %h %b %b",
                 e.n, k, count, irq, busy, e.c, e.i, e.b);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int k = 0; k < 5; k++) begin
      clr();
      case (k)
        0: begin
          wr_preset  = 1'b1;
          preset     = 16'hFFFF;
          dir        = 1'b1;
          autoreload = 1'b1;
          start      = 1'b1;
          push(16'hFFFF, 1'b0, 1'b1, "bb_load");
        end
        1, 2, 3: begin
          tick = 1'b1;
          push(16'hFFFF, 1'b1, 1'b1, "bb_term");
        end
        default: begin
          stop = 1'b1;
          push(16'hFFFF, 1'b0, 1'b0, "bb_stop");
        end
      endcase
      step();
      e = sb.pop_front();
      checks++;
      if ({count, irq, busy} !== {e.c, e.i, e.b}) begin
        errors++;
        $display("FAIL %s k=%0d count=%h irq=%b busy=%b want %h %b %b",
                 e.n, k, count, irq, busy, e.c, e.i, e.b);
      end
    end
  endtask

  task automatic test_prescale();
    exp_t         e;
    logic [W-1:0] c;
    int           ph;
    c  = 16'd9;
    ph = 0;
    for (int k = 0; k < 8; k++) begin
      clr();
      if (k == 0) begin
        wr_preset  = 1'b1;
        preset     = 16'd9;
        dir        = 1'b0;
        autoreload = 1'b0;
        prescale   = 8'd2;
        start      = 1'b1;
        push(16'd9, 1'b0, 1'b1, "ps_load");
      end else if (k < 7) begin
        tick = 1'b1;
`ifdef UDTIMER_PRESCALE_EN
        if (ph == 2) begin
          c  = c - 16'd1;
          ph = 0;
        end else begin
          ph = ph + 1;
        end
`else
        c = c - 16'd1;
`endif
        push(c, 1'b0, 1'b1, "ps_tick");
      end else begin
        stop = 1'b1;
        push(c, 1'b0, 1'b0, "ps_stop");
      end
      step();
      e = sb.pop_front();
      checks++;
      if ({count, irq, busy} !== {e.c, e.i, e.b}) begin
        errors++;
        $display("FAIL %s k=%0d count=%h irq=%b busy=%b want %h %b %b",
                 e.n, k, count, irq, busy, e.c, e.i, e.b);
      end
    end
    prescale = 8'd0;
  endtask

  initial begin
    clr();
    preset     = '0;
    dir        = 1'b0;
    autoreload = 1'b0;
    prescale   = 8'd0;
    test_reset();
    test_oneshot_down();
    test_autoreload_up();
    test_load_priority();
    test_start_stop();
    test_dir_change();
    test_back_to_back();
    test_prescale();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover=%0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
